// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT frame controller.
package fft_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } fft_ctrl_state_t;

    // LSB position of lane idx in a flat idx-packed bus of w-bit lanes
    function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/fft_8_frame_ctrl.sv
// Frame sequencer for the 8-point FFT core: collects a frame, fires the core,
// captures its results into a separate output buffer and streams them out.
module fft_8_frame_ctrl #(
    parameter int unsigned DATA_W  = fft_pkg::DATA_W,
    parameter int unsigned N       = fft_pkg::N,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_real,
    input  logic [DATA_W-1:0]   in_imag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_real,
    output logic [DATA_W-1:0]   out_imag,
    output logic                out_last,
    output logic                fft_start,
    output logic [N*DATA_W-1:0] fft_in_real,
    output logic [N*DATA_W-1:0] fft_in_imag,
    input  logic [N*DATA_W-1:0] fft_out_real,
    input  logic [N*DATA_W-1:0] fft_out_imag,
    input  logic                fft_done,
    output logic                busy,
    output logic                err_timeout,
    output logic [15:0]         frame_count
);
    import fft_pkg::fft_ctrl_state_t;
    import fft_pkg::LOAD;
    import fft_pkg::START;
    import fft_pkg::WAIT;
    import fft_pkg::lane_lsb;

    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
    localparam logic [TCNT_W-1:0] TCNT_LIM = TCNT_W'(TIMEOUT - 2);

    fft_ctrl_state_t   r_state;
    fft_ctrl_state_t   w_state_nxt;
    logic [IDX_W-1:0]  r_in_idx;
    logic [IDX_W-1:0]  r_out_idx;
    logic [TCNT_W-1:0] r_tcnt;
    logic [15:0]       r_frame_count;
    logic              r_obuf_full;
    logic              r_err_timeout;
    logic [DATA_W-1:0] r_ibuf_re [N];
    logic [DATA_W-1:0] r_ibuf_im [N];
    logic [DATA_W-1:0] r_obuf_re [N];
    logic [DATA_W-1:0] r_obuf_im [N];

    logic w_in_hs;
    logic w_out_hs;
    logic w_out_last_hs;
    logic w_capture;
    logic w_timeout;

    assign w_out_hs      = r_obuf_full && out_ready;
    assign w_out_last_hs = w_out_hs && (r_out_idx == IDX_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_state_nxt;
    end

    // Next state; capture may coincide with the final output beat of the previous frame
    always_comb begin
        w_state_nxt = r_state;
        w_in_hs     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            LOAD: begin
                w_in_hs = in_valid;
                if (in_valid && (r_in_idx == IDX_LAST)) w_state_nxt = START;
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
                if (fft_done) begin
                    if (!r_obuf_full || w_out_last_hs) begin
                        w_capture   = 1'b1;
                        w_state_nxt = LOAD;
                    end
                end else if (r_tcnt == TCNT_LIM) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Buffers, counters and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_idx      <= '0;
            r_out_idx     <= '0;
            r_tcnt        <= '0;
            r_frame_count <= '0;
            r_obuf_full   <= 1'b0;
            r_err_timeout <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                r_ibuf_re[k] <= '0;
                r_ibuf_im[k] <= '0;
                r_obuf_re[k] <= '0;
                r_obuf_im[k] <= '0;
            end
        end else begin
            if (w_in_hs) begin
                r_ibuf_re[r_in_idx] <= in_real;
                r_ibuf_im[r_in_idx] <= in_imag;
                r_in_idx <= (r_in_idx == IDX_LAST) ? '0 : r_in_idx + IDX_W'(1);
            end
            if (r_state == START) r_tcnt <= '0;
            else if (r_state == WAIT && !fft_done) r_tcnt <= r_tcnt + TCNT_W'(1);
            if (w_timeout) r_err_timeout <= 1'b1;
            if (w_out_hs) begin
                if (w_out_last_hs) begin
                    r_out_idx     <= '0;
                    r_frame_count <= r_frame_count + 16'd1;
                end else begin
                    r_out_idx <= r_out_idx + IDX_W'(1);
                end
            end
            if (w_capture) begin
                r_obuf_full <= 1'b1;
                for (int unsigned k = 0; k < N; k++) begin
                    r_obuf_re[k] <= fft_out_real[lane_lsb(k, DATA_W) +: DATA_W];
                    r_obuf_im[k] <= fft_out_imag[lane_lsb(k, DATA_W) +: DATA_W];
                end
            end else if (w_out_last_hs) begin
                r_obuf_full <= 1'b0;
            end
        end
    end

    // Core-facing input buses
    always_comb begin
        fft_in_real = '0;
        fft_in_imag = '0;
        for (int unsigned k = 0; k < N; k++) begin
            fft_in_real[lane_lsb(k, DATA_W) +: DATA_W] = r_ibuf_re[k];
            fft_in_imag[lane_lsb(k, DATA_W) +: DATA_W] = r_ibuf_im[k];
        end
    end

    // Handshake outputs are forced low while reset is held
    assign in_ready    = !rst && (r_state == LOAD);
    assign out_valid   = !rst && r_obuf_full;
    assign out_last    = !rst && r_obuf_full && (r_out_idx == IDX_LAST);
    assign fft_start   = !rst && (r_state == START);
    assign busy        = !rst && ((r_state != LOAD) || r_obuf_full);
    assign out_real    = r_obuf_re[r_out_idx];
    assign out_imag    = r_obuf_im[r_out_idx];
    assign err_timeout = r_err_timeout;
    assign frame_count = r_frame_count;

endmodule
